// File: rtl/rule_sweep_ctrl.sv
// Sweeps a 3-input logic block through input vectors 0..7, holding each for
// SETTLE_CYCLES cycles, and assembles the sampled outputs into an 8-bit rule code.
module rule_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic [7:0] code
);

  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t     state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] code_reg, code_next;
  logic [7:0] exp_reg, exp_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       match_reg, match_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
      cnt_reg   <= 8'd0;
      code_reg  <= 8'h00;
      exp_reg   <= 8'h00;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      match_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      exp_reg   <= exp_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      match_reg <= match_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    exp_next   = exp_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    match_next = match_reg;

    unique case (state_reg)
      IDLE, DONE: begin
        // abort has priority over a simultaneous start
        if (abort) begin
          state_next = IDLE;
          done_next  = 1'b0;
          match_next = 1'b0;
          busy_next  = 1'b0;
          idx_next   = 3'd0;
        end else if (start) begin
          state_next = SWEEP;
          idx_next   = 3'd0;
          cnt_next   = RELOAD;
          code_next  = 8'h00;
          exp_next   = expected;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          match_next = 1'b0;
        end
      end

      SWEEP: begin
        if (abort) begin
          state_next = IDLE;
          idx_next   = 3'd0;
          busy_next  = 1'b0;
          done_next  = 1'b0;
          match_next = 1'b0;
        end else if (cnt_reg != 8'd0) begin
          cnt_next = cnt_reg - 8'd1;
        end else begin
          // last cycle of the settle window: capture the block's response
          code_next[idx_reg] = dut_out;
          if (idx_reg != 3'd7) begin
            idx_next = idx_reg + 3'd1;
            cnt_next = RELOAD;
          end else begin
            state_next = DONE;
            idx_next   = 3'd0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            match_next = (code_next == exp_reg);
          end
        end
      end

      default: begin
        state_next = IDLE;
        idx_next   = 3'd0;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        match_next = 1'b0;
      end
    endcase
  end

  // idx is forced to 0 whenever the sweep is not running, so it drives the block directly
  assign in1   = idx_reg[2];
  assign in2   = idx_reg[1];
  assign in3   = idx_reg[0];
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign match = match_reg;
  assign code  = code_reg;

endmodule

// File: tb/tb_rule_sweep_ctrl.sv
// Directed bench for rule_sweep_ctrl: a rule-0x2E model block on a SETTLE_CYCLES=4
// instance plus a tied-high block on a SETTLE_CYCLES=1 instance.
module tb_rule_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       dut_out;
  logic       in1, in2, in3, busy, done, match;
  logic [7:0] code;

  logic       start1 = 1'b0;
  logic       abort1 = 1'b0;
  logic       in1_b, in2_b, in3_b, busy_b, done_b, match_b;
  logic [7:0] code_b;

  logic [7:0] rule_q = 8'h2E;

  typedef struct packed {
    logic [7:0] code;
    logic       match;
  } sb_t;
  sb_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // external 3-input block under test: output = rule bit at the applied vector
  assign dut_out = rule_q[{in1, in2, in3}];

  rule_sweep_ctrl #(.SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .expected(expected),
    .dut_out(dut_out), .in1(in1), .in2(in2), .in3(in3),
    .busy(busy), .done(done), .match(match), .code(code)
  );

  rule_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .expected(8'hFF),
    .dut_out(1'b1), .in1(in1_b), .in2(in2_b), .in3(in3_b),
    .busy(busy_b), .done(done_b), .match(match_b), .code(code_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on the 4-cycle instance; optionally re-pulses start at edge 10
  // and changes expected mid-sweep to show neither disturbs the result.
  task automatic run_sweep(input logic [7:0] exp_code, input bit disturb);
    bit got;
    sb_t ent;
    expected = exp_code;
    sb_q.push_back('{code: rule_q, match: (rule_q == exp_code)});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_vec", 32'({in1, in2, in3}), 32'd0);
    chk("accept_code", 32'(code), 32'h00);
    chk("accept_done", 32'(done), 32'd0);
    got = 1'b0;
    for (int e = 1; e <= 34; e++) begin
      start = (disturb && e == 10);
      if (disturb && e == 12) expected = ~exp_code;
      tick();
      start = 1'b0;
      if (e < 32) begin
        chk($sformatf("vec_e%0d", e), 32'({in1, in2, in3}), 32'(e / 4));
        chk($sformatf("busy_e%0d", e), 32'(busy), 32'd1);
        chk($sformatf("done_e%0d", e), 32'(done), 32'd0);
      end
      if (done && !got) begin
        got = 1'b1;
        chk("done_edge", 32'(e), 32'd32);
        if (sb_q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          ent = sb_q.pop_front();
          chk("sweep_code", 32'(code), 32'(ent.code));
          chk("sweep_match", 32'(match), 32'(ent.match));
          $display("sweep: expected=%02h code=%02h match=%0b", exp_code, code, match);
        end
        chk("end_vec", 32'({in1, in2, in3}), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
      end
      if (e > 32) chk("done_held", 32'(done), 32'd1);
    end
    if (!got) chk("done_timeout", 32'(got), 32'd1);
    expected = exp_code;
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_code", 32'(code), 32'h00);
    chk("rst_vec", 32'({in1, in2, in3}), 32'd0);
    reset = 1'b0;
    tick();

    // matching rule, then mismatching rule with start re-pulse and expected change
    run_sweep(8'h2E, 1'b0);
    run_sweep(8'h74, 1'b1);

    // start together with abort while in DONE: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_done", 32'(done), 32'd0);
    chk("sa_match", 32'(match), 32'd0);
    chk("sa_busy", 32'(busy), 32'd0);
    tick();
    chk("sa_idle", 32'(busy), 32'd0);
    $display("start+abort in DONE: busy=%0b done=%0b", busy, done);

    // abort sampled at edge 14 while vector 3 is applied
    expected = 8'h2E;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 13; e++) tick();
    chk("pre_abort_vec", 32'({in1, in2, in3}), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_vec", 32'({in1, in2, in3}), 32'd0);
    chk("abort_code", 32'(code), 32'h06);
    tick();
    chk("abort_hold", 32'(code), 32'h06);
    $display("abort at edge 14: code=%02h busy=%0b", code, busy);
    run_sweep(8'h2E, 1'b0);

    // asynchronous reset between edges mid-sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_vec", 32'({in1, in2, in3}), 32'd0);
    chk("arst_code", 32'(code), 32'h00);
    chk("arst_done", 32'(done), 32'd0);
    $display("async reset mid-sweep: busy=%0b code=%02h", busy, code);
    #2;
    reset = 1'b0;
    run_sweep(8'h2E, 1'b0);

    // single-cycle settle window, block output tied high
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("s1_accept_vec", 32'({in1_b, in2_b, in3_b}), 32'd0);
    chk("s1_accept_busy", 32'(busy_b), 32'd1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e < 8) begin
        chk($sformatf("s1_vec_e%0d", e), 32'({in1_b, in2_b, in3_b}), 32'(e));
        chk($sformatf("s1_done_e%0d", e), 32'(done_b), 32'd0);
      end
    end
    chk("s1_done", 32'(done_b), 32'd1);
    chk("s1_code", 32'(code_b), 32'hFF);
    chk("s1_match", 32'(match_b), 32'd1);
    chk("s1_busy", 32'(busy_b), 32'd0);
    $display("settle=1 sweep: code=%02h done=%0b", code_b, done_b);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence finished");
    $fatal(1, "watchdog");
  end

endmodule
